// File: rtl/data_mem_unit.sv
// Word-organised data memory for the single-cycle MIPS core: lw/sw/lb/sb with
// combinational reads, synchronous writes and a registered store-trace port.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        lb_sel,
  input  logic        sb_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        trace_valid,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   cur_word;
  logic [31:0]   merged;
  logic [7:0]    lane_byte;

  // Upper address bits are dropped on purpose: accesses alias modulo the array size.
  assign idx      = addr[AW+1:2];
  assign lane     = addr[1:0];
  assign cur_word = mem[idx];

  always_comb begin
    lane_byte = cur_word[7:0];
    merged    = wdata;
    case (lane)
      2'd0: lane_byte = cur_word[7:0];
      2'd1: lane_byte = cur_word[15:8];
      2'd2: lane_byte = cur_word[23:16];
      default: lane_byte = cur_word[31:24];
    endcase
    if (sb_sel) begin
      merged = cur_word;
      case (lane)
        2'd0: merged[7:0]   = wdata[7:0];
        2'd1: merged[15:8]  = wdata[7:0];
        2'd2: merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end
  end

  // Reads always see pre-edge contents; there is no write-first bypass.
  assign rdata = lb_sel ? {{24{lane_byte[7]}}, lane_byte} : cur_word;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (MemWrite) begin
      mem[idx] <= merged;
    end
  end

  // trace_valid pulses for one cycle per retired store; addr/data hold between stores.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else if (MemWrite) begin
      trace_valid <= 1'b1;
      trace_addr  <= {addr[31:2], 2'b00};
      trace_data  <= merged;
    end else begin
      trace_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed vector table for the listed corner cases,
// then randomized traffic against an array-based reference model.
module tb_data_mem_unit;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        lb_sel;
  logic        sb_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        trace_valid;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  int total = 0;
  int bad   = 0;

  data_mem_unit #(.DEPTH_WORDS(1024), .AW(10)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .lb_sel(lb_sel), .sb_sel(sb_sel),
    .addr(addr), .wdata(wdata), .rdata(rdata), .trace_valid(trace_valid),
    .trace_addr(trace_addr), .trace_data(trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic        lbs;
    logic        sbs;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_tv;
    logic [31:0] exp_ta;
    logic [31:0] exp_td;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, we, lbs, sbs, input logic [31:0] a, wd,
                              input logic chk_rd, input logic [31:0] exp_rd,
                              input logic exp_tv, input logic [31:0] exp_ta, exp_td);
    vec_t v;
    v.rst_n = rst_n; v.we = we; v.lbs = lbs; v.sbs = sbs; v.a = a; v.wd = wd;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_tv = exp_tv; v.exp_ta = exp_ta; v.exp_td = exp_td;
    return v;
  endfunction

  task automatic drive(input logic rst_n, we, lbs, sbs, input logic [31:0] a, wd);
    reset = rst_n; MemWrite = we; lb_sel = lbs; sb_sel = sbs; addr = a; wdata = wd;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h expected=%08h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain word array plus last-store trace registers.
  logic [31:0] mm [1024];
  logic        m_tv;
  logic [31:0] m_ta, m_td;

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic lbs);
    logic [31:0] w;
    int          b;
    w = mm[(a >> 2) % 1024];
    b = int'((w >> (8 * (a % 4))) & 32'hFF);
    if (!lbs) return w;
    if (b >= 128) b = b - 256;
    return 32'(b);
  endfunction

  task automatic model_edge(input logic rst_n, we, sbs, input logic [31:0] a, wd);
    logic [31:0] w, nw, mask;
    int          lane;
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mm[i] = 32'h0;
      m_tv = 1'b0; m_ta = 32'h0; m_td = 32'h0;
    end else if (we) begin
      w    = mm[(a >> 2) % 1024];
      lane = int'(a % 4);
      mask = 32'hFF << (8 * lane);
      nw   = sbs ? ((w & ~mask) | ((wd & 32'hFF) << (8 * lane))) : wd;
      mm[(a >> 2) % 1024] = nw;
      m_tv = 1'b1; m_ta = a - (a % 4); m_td = nw;
    end else begin
      m_tv = 1'b0;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    //                rst we lb sb addr          wdata         chk exp_rd        tv ta            td
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0,         0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h4,        32'h0,        1, 32'h0,         0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'hFFC,      32'h0,        1, 32'h0,         0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h10,       32'h12345678, 1, 32'h0,         1, 32'h10,       32'h12345678));
    vecs.push_back(mk(1, 0, 0, 0, 32'h10,       32'h0,        1, 32'h12345678,  0, 32'h10,       32'h12345678));
    vecs.push_back(mk(1, 1, 0, 1, 32'h12,       32'hAAAAAA9C, 1, 32'h12345678,  1, 32'h10,       32'h129C5678));
    vecs.push_back(mk(1, 0, 1, 0, 32'h12,       32'h0,        1, 32'hFFFFFF9C,  0, 32'h10,       32'h129C5678));
    vecs.push_back(mk(1, 0, 1, 0, 32'h13,       32'h0,        1, 32'h00000012,  0, 32'h10,       32'h129C5678));
    vecs.push_back(mk(1, 0, 1, 0, 32'h10,       32'h0,        1, 32'h00000078,  0, 32'h10,       32'h129C5678));
    vecs.push_back(mk(1, 0, 0, 0, 32'h10,       32'h0,        1, 32'h129C5678,  0, 32'h10,       32'h129C5678));
    vecs.push_back(mk(1, 1, 0, 0, 32'h1003,     32'hDEADBEEF, 1, 32'h0,         1, 32'h1000,     32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        1, 32'hDEADBEEF,  0, 32'h1000,     32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 0, 0, 32'h20,       32'h55,       1, 32'h0,         0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h20,       32'h0,        1, 32'h0,         0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0,         0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h24,       32'h1,        1, 32'h0,         1, 32'h24,       32'h1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h24,       32'h0,        1, 32'h1,         0, 32'h24,       32'h1));
    vecs.push_back(mk(1, 1, 1, 1, 32'h24,       32'h80,       1, 32'h1,         1, 32'h24,       32'h80));
    vecs.push_back(mk(1, 0, 1, 0, 32'h24,       32'h0,        1, 32'hFFFFFF80,  0, 32'h24,       32'h80));
    vecs.push_back(mk(1, 0, 0, 1, 32'h25,       32'hFF,       1, 32'h80,        0, 32'h24,       32'h80));
    vecs.push_back(mk(1, 0, 0, 0, 32'h24,       32'h0,        1, 32'h80,        0, 32'h24,       32'h80));
    vecs.push_back(mk(1, 1, 0, 1, 32'h27,       32'h1234567F, 1, 32'h80,        1, 32'h24,       32'h7F000080));
    vecs.push_back(mk(1, 0, 1, 0, 32'h27,       32'h0,        1, 32'h0000007F,  0, 32'h24,       32'h7F000080));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].we, vecs[i].lbs, vecs[i].sbs, vecs[i].a, vecs[i].wd);
      @(negedge clk);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      @(posedge clk); #1;
      check($sformatf("vec%0d_trace_valid", i), {31'b0, trace_valid}, {31'b0, vecs[i].exp_tv});
      check($sformatf("vec%0d_trace_addr", i), trace_addr, vecs[i].exp_ta);
      check($sformatf("vec%0d_trace_data", i), trace_data, vecs[i].exp_td);
    end

    // Randomized phase: start from a known reset, then mixed traffic in a small window.
    model_edge(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      logic        r, we, lbs, sbs;
      logic [31:0] a, wd, exp_rd;
      r   = ($urandom_range(0, 39) != 0);
      we  = 1'($urandom_range(0, 1));
      lbs = 1'($urandom_range(0, 1));
      sbs = 1'($urandom_range(0, 1));
      a   = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      wd  = $urandom;
      drive(r, we, lbs, sbs, a, wd);
      exp_rd = model_read(a, lbs);
      @(negedge clk);
      check("rand_rdata", rdata, exp_rd);
      model_edge(r, we, sbs, a, wd);
      @(posedge clk); #1;
      check("rand_trace_valid", {31'b0, trace_valid}, {31'b0, m_tv});
      check("rand_trace_addr", trace_addr, m_ta);
      check("rand_trace_data", trace_data, m_td);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
